// File: rtl/dec_swc_stage.sv
// RV32I decode stage: registers the fetched instruction and its one-hot decode.
// Define DEC_ZICSR_EN to decode MISC-MEM / SYSTEM (fence, ecall, csr*) flags.
module dec_swc_stage #(
  parameter logic [3:0] DEC_CYCLE = 4'd1
) (
  input  logic        hclk,
  input  logic        hrstn,
  input  logic [3:0]  cycle_cnt,
  input  logic        ifu_dec_stall,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_out,
  output logic dec_lui, dec_auipc, dec_jal, dec_jalr,
  output logic dec_beq, dec_bne, dec_blt, dec_bge, dec_bltu, dec_bgeu,
  output logic dec_lb, dec_lh, dec_lw, dec_lbu, dec_lhu, dec_sb, dec_sh, dec_sw,
  output logic dec_addi, dec_slti, dec_sltiu, dec_xori, dec_ori, dec_andi,
  output logic dec_slli, dec_srli, dec_srai,
  output logic dec_add, dec_sub, dec_sll, dec_slt, dec_sltu,
  output logic dec_xor, dec_srl, dec_sra, dec_or, dec_and,
  output logic dec_fence, dec_fence_i, dec_ecall, dec_ebreak,
  output logic dec_csrrw, dec_csrrs, dec_csrrc, dec_csrrwi, dec_csrrsi, dec_csrrci,
  output logic dec_upper_en, dec_imm_en, dec_reg_en, dec_jump_en,
  output logic dec_branch_en, dec_load_en, dec_store_en,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [4:0]  dec_rd,
  output logic [11:0] dec_imm_type_i,
  output logic [11:0] dec_imm_type_s,
  output logic [12:0] dec_imm_type_b,
  output logic [19:0] dec_imm_type_u,
  output logic [20:0] dec_imm_type_j
);

  typedef struct packed {
    logic lui, auipc, jal, jalr;
    logic beq, bne, blt, bge, bltu, bgeu;
    logic lb, lh, lw, lbu, lhu, sb, sh, sw;
    logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
    logic add, sub, sll, slt, sltu, xor_f, srl, sra, or_f, and_f;
    logic fence, fence_i, ecall, ebreak;
    logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
  } dec_flags_t;

  dec_flags_t  flags_c, flags_d, flags_q;
  logic [31:0] inst_d, inst_q;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  assign opcode = inst_in[6:0];
  assign funct3 = inst_in[14:12];
  assign funct7 = inst_in[31:25];

  // Combinational decode of the incoming instruction; anything unmatched stays all-zero.
  always_comb begin
    flags_c = '0;
    case (opcode)
      7'b0110111: flags_c.lui   = 1'b1;
      7'b0010111: flags_c.auipc = 1'b1;
      7'b1101111: flags_c.jal   = 1'b1;
      7'b1100111: flags_c.jalr  = (funct3 == 3'b000);
      7'b1100011: begin
        case (funct3)
          3'b000: flags_c.beq  = 1'b1;
          3'b001: flags_c.bne  = 1'b1;
          3'b100: flags_c.blt  = 1'b1;
          3'b101: flags_c.bge  = 1'b1;
          3'b110: flags_c.bltu = 1'b1;
          3'b111: flags_c.bgeu = 1'b1;
          default: ;
        endcase
      end
      7'b0000011: begin
        case (funct3)
          3'b000: flags_c.lb  = 1'b1;
          3'b001: flags_c.lh  = 1'b1;
          3'b010: flags_c.lw  = 1'b1;
          3'b100: flags_c.lbu = 1'b1;
          3'b101: flags_c.lhu = 1'b1;
          default: ;
        endcase
      end
      7'b0100011: begin
        case (funct3)
          3'b000: flags_c.sb = 1'b1;
          3'b001: flags_c.sh = 1'b1;
          3'b010: flags_c.sw = 1'b1;
          default: ;
        endcase
      end
      7'b0010011: begin
        case (funct3)
          3'b000: flags_c.addi  = 1'b1;
          3'b010: flags_c.slti  = 1'b1;
          3'b011: flags_c.sltiu = 1'b1;
          3'b100: flags_c.xori  = 1'b1;
          3'b110: flags_c.ori   = 1'b1;
          3'b111: flags_c.andi  = 1'b1;
          3'b001: flags_c.slli  = (funct7 == 7'b0000000);
          3'b101: begin
            flags_c.srli = (funct7 == 7'b0000000);
            flags_c.srai = (funct7 == 7'b0100000);
          end
          default: ;
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: flags_c.add   = 1'b1;
            3'b001: flags_c.sll   = 1'b1;
            3'b010: flags_c.slt   = 1'b1;
            3'b011: flags_c.sltu  = 1'b1;
            3'b100: flags_c.xor_f = 1'b1;
            3'b101: flags_c.srl   = 1'b1;
            3'b110: flags_c.or_f  = 1'b1;
            default: flags_c.and_f = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000) begin
          flags_c.sub = (funct3 == 3'b000);
          flags_c.sra = (funct3 == 3'b101);
        end
      end
`ifdef DEC_ZICSR_EN
      7'b0001111: begin
        flags_c.fence   = (funct3 == 3'b000);
        flags_c.fence_i = (funct3 == 3'b001);
      end
      7'b1110011: begin
        case (funct3)
          3'b000: begin
            flags_c.ecall  = (inst_in[31:20] == 12'd0);
            flags_c.ebreak = (inst_in[31:20] == 12'd1);
          end
          3'b001: flags_c.csrrw  = 1'b1;
          3'b010: flags_c.csrrs  = 1'b1;
          3'b011: flags_c.csrrc  = 1'b1;
          3'b101: flags_c.csrrwi = 1'b1;
          3'b110: flags_c.csrrsi = 1'b1;
          3'b111: flags_c.csrrci = 1'b1;
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
  end

  // Stall overrides the capture slot.
  always_comb begin
    inst_d  = inst_q;
    flags_d = flags_q;
    if ((cycle_cnt == DEC_CYCLE) && !ifu_dec_stall) begin
      inst_d  = inst_in;
      flags_d = flags_c;
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      inst_q  <= '0;
      flags_q <= '0;
    end else begin
      inst_q  <= inst_d;
      flags_q <= flags_d;
    end
  end

  assign inst_out = inst_q;
  assign {dec_lui, dec_auipc, dec_jal, dec_jalr,
          dec_beq, dec_bne, dec_blt, dec_bge, dec_bltu, dec_bgeu,
          dec_lb, dec_lh, dec_lw, dec_lbu, dec_lhu, dec_sb, dec_sh, dec_sw,
          dec_addi, dec_slti, dec_sltiu, dec_xori, dec_ori, dec_andi,
          dec_slli, dec_srli, dec_srai,
          dec_add, dec_sub, dec_sll, dec_slt, dec_sltu,
          dec_xor, dec_srl, dec_sra, dec_or, dec_and,
          dec_fence, dec_fence_i, dec_ecall, dec_ebreak,
          dec_csrrw, dec_csrrs, dec_csrrc, dec_csrrwi, dec_csrrsi, dec_csrrci} = flags_q;

  assign dec_upper_en  = flags_q.lui | flags_q.auipc;
  assign dec_imm_en    = flags_q.addi | flags_q.slti | flags_q.sltiu | flags_q.xori |
                         flags_q.ori | flags_q.andi | flags_q.slli | flags_q.srli | flags_q.srai;
  assign dec_reg_en    = flags_q.add | flags_q.sub | flags_q.sll | flags_q.slt | flags_q.sltu |
                         flags_q.xor_f | flags_q.srl | flags_q.sra | flags_q.or_f | flags_q.and_f;
  assign dec_jump_en   = flags_q.jal | flags_q.jalr;
  assign dec_branch_en = flags_q.beq | flags_q.bne | flags_q.blt | flags_q.bge |
                         flags_q.bltu | flags_q.bgeu;
  assign dec_load_en   = flags_q.lb | flags_q.lh | flags_q.lw | flags_q.lbu | flags_q.lhu;
  assign dec_store_en  = flags_q.sb | flags_q.sh | flags_q.sw;

  // Raw fields straight from the held instruction; execute does sign extension.
  assign dec_rs1        = inst_q[19:15];
  assign dec_rs2        = inst_q[24:20];
  assign dec_rd         = inst_q[11:7];
  assign dec_imm_type_i = inst_q[31:20];
  assign dec_imm_type_s = {inst_q[31:25], inst_q[11:7]};
  assign dec_imm_type_b = {inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign dec_imm_type_u = inst_q[31:12];
  assign dec_imm_type_j = {inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

endmodule

// File: tb/tb_dec_swc_stage.sv
// Directed table-driven bench for dec_swc_stage; expected values hand-computed.
module tb_dec_swc_stage;
  logic        hclk = 1'b0;
  logic        hrstn;
  logic [3:0]  cycle_cnt;
  logic        ifu_dec_stall;
  logic [31:0] inst_in, inst_out;
  logic dec_lui, dec_auipc, dec_jal, dec_jalr;
  logic dec_beq, dec_bne, dec_blt, dec_bge, dec_bltu, dec_bgeu;
  logic dec_lb, dec_lh, dec_lw, dec_lbu, dec_lhu, dec_sb, dec_sh, dec_sw;
  logic dec_addi, dec_slti, dec_sltiu, dec_xori, dec_ori, dec_andi;
  logic dec_slli, dec_srli, dec_srai;
  logic dec_add, dec_sub, dec_sll, dec_slt, dec_sltu;
  logic dec_xor, dec_srl, dec_sra, dec_or, dec_and;
  logic dec_fence, dec_fence_i, dec_ecall, dec_ebreak;
  logic dec_csrrw, dec_csrrs, dec_csrrc, dec_csrrwi, dec_csrrsi, dec_csrrci;
  logic dec_upper_en, dec_imm_en, dec_reg_en, dec_jump_en;
  logic dec_branch_en, dec_load_en, dec_store_en;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [11:0] dec_imm_type_i, dec_imm_type_s;
  logic [12:0] dec_imm_type_b;
  logic [19:0] dec_imm_type_u;
  logic [20:0] dec_imm_type_j;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 hclk = ~hclk;

  dec_swc_stage dut (
    .hclk(hclk), .hrstn(hrstn), .cycle_cnt(cycle_cnt), .ifu_dec_stall(ifu_dec_stall),
    .inst_in(inst_in), .inst_out(inst_out),
    .dec_lui(dec_lui), .dec_auipc(dec_auipc), .dec_jal(dec_jal), .dec_jalr(dec_jalr),
    .dec_beq(dec_beq), .dec_bne(dec_bne), .dec_blt(dec_blt), .dec_bge(dec_bge),
    .dec_bltu(dec_bltu), .dec_bgeu(dec_bgeu),
    .dec_lb(dec_lb), .dec_lh(dec_lh), .dec_lw(dec_lw), .dec_lbu(dec_lbu), .dec_lhu(dec_lhu),
    .dec_sb(dec_sb), .dec_sh(dec_sh), .dec_sw(dec_sw),
    .dec_addi(dec_addi), .dec_slti(dec_slti), .dec_sltiu(dec_sltiu), .dec_xori(dec_xori),
    .dec_ori(dec_ori), .dec_andi(dec_andi), .dec_slli(dec_slli), .dec_srli(dec_srli),
    .dec_srai(dec_srai),
    .dec_add(dec_add), .dec_sub(dec_sub), .dec_sll(dec_sll), .dec_slt(dec_slt),
    .dec_sltu(dec_sltu), .dec_xor(dec_xor), .dec_srl(dec_srl), .dec_sra(dec_sra),
    .dec_or(dec_or), .dec_and(dec_and),
    .dec_fence(dec_fence), .dec_fence_i(dec_fence_i), .dec_ecall(dec_ecall),
    .dec_ebreak(dec_ebreak), .dec_csrrw(dec_csrrw), .dec_csrrs(dec_csrrs),
    .dec_csrrc(dec_csrrc), .dec_csrrwi(dec_csrrwi), .dec_csrrsi(dec_csrrsi),
    .dec_csrrci(dec_csrrci),
    .dec_upper_en(dec_upper_en), .dec_imm_en(dec_imm_en), .dec_reg_en(dec_reg_en),
    .dec_jump_en(dec_jump_en), .dec_branch_en(dec_branch_en), .dec_load_en(dec_load_en),
    .dec_store_en(dec_store_en),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_imm_type_i(dec_imm_type_i), .dec_imm_type_s(dec_imm_type_s),
    .dec_imm_type_b(dec_imm_type_b), .dec_imm_type_u(dec_imm_type_u),
    .dec_imm_type_j(dec_imm_type_j)
  );

  // Flag index: lui=0 ... csrrci=46 (bit position in act_flags).
  logic [46:0] act_flags;
  logic [6:0]  act_en;
  assign act_flags = {dec_csrrci, dec_csrrsi, dec_csrrwi, dec_csrrc, dec_csrrs, dec_csrrw,
                      dec_ebreak, dec_ecall, dec_fence_i, dec_fence,
                      dec_and, dec_or, dec_sra, dec_srl, dec_xor, dec_sltu, dec_slt,
                      dec_sll, dec_sub, dec_add,
                      dec_srai, dec_srli, dec_slli, dec_andi, dec_ori, dec_xori,
                      dec_sltiu, dec_slti, dec_addi,
                      dec_sw, dec_sh, dec_sb, dec_lhu, dec_lbu, dec_lw, dec_lh, dec_lb,
                      dec_bgeu, dec_bltu, dec_bge, dec_blt, dec_bne, dec_beq,
                      dec_jalr, dec_jal, dec_auipc, dec_lui};
  assign act_en = {dec_upper_en, dec_imm_en, dec_reg_en, dec_jump_en,
                   dec_branch_en, dec_load_en, dec_store_en};

  typedef struct {
    logic        stall;
    logic [3:0]  cnt;
    logic [31:0] inst;
    logic [31:0] x_inst;
    int          x_flag;   // -1: no flag set
    logic [6:0]  x_en;     // {upper, imm, reg, jump, branch, load, store}
    logic [4:0]  x_rd, x_rs1, x_rs2;
    logic [11:0] x_i, x_s;
    logic [12:0] x_b;
    logic [19:0] x_u;
    logic [20:0] x_j;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_inst"}, 64'(inst_out), 64'd0);
    check({tag, "_flags"}, 64'(act_flags), 64'd0);
    check({tag, "_en"}, 64'(act_en), 64'd0);
    check({tag, "_regs"}, 64'({dec_rd, dec_rs1, dec_rs2}), 64'd0);
    check({tag, "_imms"}, 64'({dec_imm_type_i, dec_imm_type_s, dec_imm_type_b}), 64'd0);
    check({tag, "_immuj"}, 64'({dec_imm_type_u, dec_imm_type_j}), 64'd0);
  endtask

  initial begin
    int ecall_flag;
    logic [46:0] exp_flags;
`ifdef DEC_ZICSR_EN
    ecall_flag = 39;
`else
    ecall_flag = -1;
`endif
    //            stall cnt   inst          exp_inst     flag en        rd    rs1   rs2   I        S        B         U         J
    vecs[0]  = '{1'b0, 4'd1, 32'h00500093, 32'h00500093, 18, 7'b0100000, 5'd1, 5'd0, 5'd5, 12'h005, 12'h001, 13'h0800, 20'h00500, 21'h000804};
    vecs[1]  = '{1'b0, 4'd1, 32'h002081B3, 32'h002081B3, 27, 7'b0010000, 5'd3, 5'd1, 5'd2, 12'h002, 12'h003, 13'h0802, 20'h00208, 21'h008002};
    vecs[2]  = '{1'b0, 4'd1, 32'h402081B3, 32'h402081B3, 28, 7'b0010000, 5'd3, 5'd1, 5'd2, 12'h402, 12'h403, 13'h0C02, 20'h40208, 21'h008402};
    vecs[3]  = '{1'b0, 4'd1, 32'h00208463, 32'h00208463, 4,  7'b0000100, 5'd8, 5'd1, 5'd2, 12'h002, 12'h008, 13'h0008, 20'h00208, 21'h008002};
    vecs[4]  = '{1'b0, 4'd1, 32'hFFC12283, 32'hFFC12283, 12, 7'b0000010, 5'd5, 5'd2, 5'd28, 12'hFFC, 12'hFE5, 13'h1FE4, 20'hFFC12, 21'h1127FC};
    vecs[5]  = '{1'b0, 4'd1, 32'h00512423, 32'h00512423, 17, 7'b0000001, 5'd8, 5'd2, 5'd5, 12'h005, 12'h008, 13'h0008, 20'h00512, 21'h012804};
    vecs[6]  = '{1'b1, 4'd1, 32'h00000073, 32'h00512423, 17, 7'b0000001, 5'd8, 5'd2, 5'd5, 12'h005, 12'h008, 13'h0008, 20'h00512, 21'h012804};
    vecs[7]  = '{1'b0, 4'd2, 32'h00000073, 32'h00512423, 17, 7'b0000001, 5'd8, 5'd2, 5'd5, 12'h005, 12'h008, 13'h0008, 20'h00512, 21'h012804};
    vecs[8]  = '{1'b1, 4'd0, 32'h00000073, 32'h00512423, 17, 7'b0000001, 5'd8, 5'd2, 5'd5, 12'h005, 12'h008, 13'h0008, 20'h00512, 21'h012804};
    vecs[9]  = '{1'b0, 4'd1, 32'h00000073, 32'h00000073, ecall_flag, 7'b0000000, 5'd0, 5'd0, 5'd0, 12'h000, 12'h000, 13'h0000, 20'h00000, 21'h000000};
    vecs[10] = '{1'b0, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 7'b0000000, 5'd31, 5'd31, 5'd31, 12'hFFF, 12'hFFF, 13'h1FFE, 20'hFFFFF, 21'h1FFFFE};
    vecs[11] = '{1'b0, 4'd1, 32'h0000006F, 32'h0000006F, 2,  7'b0001000, 5'd0, 5'd0, 5'd0, 12'h000, 12'h000, 13'h0000, 20'h00000, 21'h000000};
    vecs[12] = '{1'b0, 4'd1, 32'h4030D093, 32'h4030D093, 26, 7'b0100000, 5'd1, 5'd1, 5'd3, 12'h403, 12'h401, 13'h0C00, 20'h4030D, 21'h00DC02};
    vecs[13] = '{1'b0, 4'd1, 32'h123450B7, 32'h123450B7, 0,  7'b1000000, 5'd1, 5'd8, 5'd3, 12'h123, 12'h121, 13'h0920, 20'h12345, 21'h045922};

    // Reset held across a live capture slot with a non-zero instruction.
    hrstn = 1'b0;
    cycle_cnt = 4'd1;
    ifu_dec_stall = 1'b0;
    inst_in = 32'hFFFFFFFF;
    repeat (2) @(posedge hclk);
    #1;
    check_all_zero("reset");
    $display("txn reset: inst_out=%08h", inst_out);
    @(negedge hclk);
    hrstn = 1'b1;

    for (int k = 0; k < 14; k++) begin
      @(negedge hclk);
      ifu_dec_stall = vecs[k].stall;
      cycle_cnt     = vecs[k].cnt;
      inst_in       = vecs[k].inst;
      @(posedge hclk);
      #1;
      exp_flags = (vecs[k].x_flag < 0) ? 47'd0 : (47'd1 << vecs[k].x_flag);
      $display("txn %0d: stall=%0b cnt=%0d inst=%08h -> inst_out=%08h flags=%012h en=%07b",
               k, vecs[k].stall, vecs[k].cnt, vecs[k].inst, inst_out, act_flags, act_en);
      check($sformatf("v%0d_inst", k), 64'(inst_out), 64'(vecs[k].x_inst));
      check($sformatf("v%0d_flags", k), 64'(act_flags), 64'(exp_flags));
      check($sformatf("v%0d_en", k), 64'(act_en), 64'(vecs[k].x_en));
      check($sformatf("v%0d_rd", k), 64'(dec_rd), 64'(vecs[k].x_rd));
      check($sformatf("v%0d_rs1", k), 64'(dec_rs1), 64'(vecs[k].x_rs1));
      check($sformatf("v%0d_rs2", k), 64'(dec_rs2), 64'(vecs[k].x_rs2));
      check($sformatf("v%0d_imm_i", k), 64'(dec_imm_type_i), 64'(vecs[k].x_i));
      check($sformatf("v%0d_imm_s", k), 64'(dec_imm_type_s), 64'(vecs[k].x_s));
      check($sformatf("v%0d_imm_b", k), 64'(dec_imm_type_b), 64'(vecs[k].x_b));
      check($sformatf("v%0d_imm_u", k), 64'(dec_imm_type_u), 64'(vecs[k].x_u));
      check($sformatf("v%0d_imm_j", k), 64'(dec_imm_type_j), 64'(vecs[k].x_j));
    end

    // Hold when the slot is missed right after a capture.
    @(negedge hclk);
    cycle_cnt = 4'd3;
    inst_in = 32'h00000013;
    @(posedge hclk);
    #1;
    $display("txn hold: cnt=3 inst=%08h -> inst_out=%08h", inst_in, inst_out);
    check("hold_inst", 64'(inst_out), 64'h123450B7);
    check("hold_lui", 64'(dec_lui), 64'd1);

    // Asynchronous reset asserted between edges clears outputs without a clock.
    #2;
    hrstn = 1'b0;
    #1;
    $display("txn async_reset: inst_out=%08h", inst_out);
    check_all_zero("async_rst");
    #1;
    hrstn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dec_swc_stage.md
Name: dec_swc_stage

Overview:
Instruction-decode pipeline stage of the SwitchMCU RV32I core. It sits between the fetch unit (ifu) and the execute unit (exu_top). It registers the fetched instruction and produces one-hot instruction flags, class enables, register indices and raw immediate fields. Capture is gated by the core's shared 4-bit cycle counter and the fetch stall.

Parameters:
DEC_CYCLE, 4'd1, cycle_cnt value on which the stage captures a new instruction.

Ports:
hclk  input  1  core clock; all state updates on rising edge
hrstn  input  1  reset, asynchronous, active-low
cycle_cnt  input  4  core cycle/slot counter
ifu_dec_stall  input  1  fetch stall; 1 freezes this stage
inst_in  input  32  instruction from fetch
inst_out  output  32  registered instruction forwarded to execute
dec_lui/auipc/jal/jalr/beq/bne/blt/bge/bltu/bgeu  output  1 each  one-hot op flags
dec_lb/lh/lw/lbu/lhu/sb/sh/sw  output  1 each  load/store op flags
dec_addi/slti/sltiu/xori/ori/andi/slli/srli/srai  output  1 each  OP-IMM flags
dec_add/sub/sll/slt/sltu/xor/srl/sra/or/and  output  1 each  OP flags
dec_fence/fence_i/ecall/ebreak/csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci  output  1 each  system flags
dec_upper_en/imm_en/reg_en/jump_en/branch_en/load_en/store_en  output  1 each  class enables
dec_rs1, dec_rs2, dec_rd  output  5 each  register indices
dec_imm_type_i, dec_imm_type_s  output  12 each  I/S immediates
dec_imm_type_b  output  13  B immediate
dec_imm_type_u  output  20  U immediate
dec_imm_type_j  output  21  J immediate

Behaviour:
- Reset (hrstn=0, asynchronous): every output is 0, including inst_out.
- Capture: on a rising edge with cycle_cnt==DEC_CYCLE and ifu_dec_stall==0, all outputs load from the combinational decode of inst_in. Latency is 1 edge. On any other edge, all outputs hold.
- Stall has priority: if stall=1 on the DEC_CYCLE edge, nothing is captured and outputs hold.
- Decode keys on opcode inst[6:0], funct3 inst[14:12] and funct7 inst[31:25]:
  - LUI 0110111 and AUIPC 0010111.
  - JAL 1101111.
  - JALR 1100111 with f3=000.
  - BRANCH 1100011, f3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
  - LOAD 0000011, f3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - STORE 0100011, f3: 000 sb, 001 sh, 010 sw.
  - OP-IMM 0010011, f3: 000 addi, 010 slti, 011 sltiu, 100 xori, 110 ori, 111 andi. f3=001 with f7=0000000 is slli. f3=101 with f7=0000000 is srli; with f7=0100000 it is srai.
  - OP 0110011: with f7=0000000, f3 000..111 are add, sll, slt, sltu, xor, srl, or, and. With f7=0100000, f3=000 is sub and f3=101 is sra.
  - MISC-MEM 0001111, f3: 000 fence, 001 fence_i.
  - SYSTEM 1110011: f3=000 with inst[31:20]=0 is ecall; with inst[31:20]=1 it is ebreak. f3 001/010/011/101/110/111 are csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci.
- At most one op flag is high. An unrecognised encoding drives all flags and all class enables to 0.
- Class enables:
  - upper_en = lui|auipc
  - imm_en = any OP-IMM flag
  - reg_en = any OP flag
  - jump_en = jal|jalr
  - branch_en = any branch
  - load_en = any load
  - store_en = any store
- Register indices are the raw fields, regardless of format: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7].
- Immediates are raw and unsigned-extended (sign extension is done in execute); they are produced for every instruction:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = inst[31:12]
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- inst_out equals the captured inst_in.

Optional Feature:
DEC_ZICSR_EN:
- Defined: fence, fence_i, ecall, ebreak and the six csr* flags decode as specified above.
- Undefined: those ten flags are tied to 0, so MISC-MEM and SYSTEM encodings are unrecognised (all flags 0). inst_out, indices and immediates are still captured.

Test Plan:
- Reset → all outputs 0. Then inst_in=0x00500093 on a DEC_CYCLE edge → dec_addi=1, imm_en=1, rd=1, rs1=0, imm_type_i=12'h005.
- 0x002081B3 → dec_add=1, reg_en=1, rd=3, rs1=1, rs2=2. Then 0x402081B3 → dec_sub=1 and dec_add=0.
- 0x00208463 → dec_beq=1, branch_en=1, imm_type_b=13'h008. 0xFFC12283 → dec_lw=1, load_en=1, rd=5, imm_type_i=12'hFFC.
- 0x00512423 → dec_sw=1, store_en=1, imm_type_s=12'h008, rs2=5.
- With ifu_dec_stall=1, or cycle_cnt≠DEC_CYCLE, present 0x00000073 → outputs unchanged. Release the stall on a DEC_CYCLE edge → dec_ecall=1 if DEC_ZICSR_EN is defined, else all flags 0 and inst_out=0x00000073.
- 0xFFFFFFFF → all flags 0. Assert hrstn low mid-cycle → outputs clear immediately.
